// File: rtl/data_memory_param.sv
// Line-oriented backing memory below the L1 data cache: one line read or write at a time,
// independent read/write latencies, per-byte write mask, out-of-range error flag.
module data_memory_param #(
    parameter int LINE_BITS     = 256,
    parameter int DEPTH         = 512,
    parameter int ADDR_BITS     = 32,
    parameter int READ_LATENCY  = 10,
    parameter int WRITE_LATENCY = 10
) (
    input  logic                   clock_i,
    input  logic                   reset_n_i,
    input  logic                   flush_i,
    input  logic                   enable_i,
    input  logic                   write_i,
    input  logic [ADDR_BITS-1:0]   addr_i,
    input  logic [LINE_BITS-1:0]   data_i,
    input  logic [LINE_BITS/8-1:0] mask_i,
    output logic                   busy_o,
    output logic                   ack_o,
    output logic                   error_o,
    output logic [LINE_BITS-1:0]   data_o
);
    localparam int NBYTES = LINE_BITS / 8;
    localparam int OFF    = $clog2(NBYTES);
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int MAXL   = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CW     = (MAXL > 1) ? $clog2(MAXL) : 1;
    localparam logic [CW-1:0]      RD_LAST = CW'(READ_LATENCY - 1);
    localparam logic [CW-1:0]      WR_LAST = CW'(WRITE_LATENCY - 1);
    localparam logic [ADDR_BITS:0] DEPTH_W = (ADDR_BITS + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t               state, state_nx;
    logic [CW-1:0]        count;
    logic                 req_write;
    logic [ADDR_BITS-1:0] req_idx;
    logic [LINE_BITS-1:0] req_data;
    logic [NBYTES-1:0]    req_mask;
    logic                 error_q;
    logic [LINE_BITS-1:0] rdata_q;
    logic                 accept, complete, in_range;

    logic [LINE_BITS-1:0] mem [DEPTH];

    // Full shifted index is kept so the range check sees every upper address bit.
    assign in_range = {1'b0, req_idx} < DEPTH_W;
    assign accept   = (state != S_BUSY) && enable_i && !flush_i;
    assign complete = (state == S_BUSY) && !flush_i &&
                      (count == (req_write ? WR_LAST : RD_LAST));

    always_comb begin
        state_nx = state;
        if (flush_i) state_nx = S_IDLE;
        else begin
            case (state)
                S_BUSY:  if (complete) state_nx = S_DONE;
                default: state_nx = accept ? S_BUSY : S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state     <= S_IDLE;
            count     <= '0;
            error_q   <= 1'b0;
            rdata_q   <= '0;
            req_write <= 1'b0;
            req_idx   <= '0;
            req_data  <= '0;
            req_mask  <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                req_write <= write_i;
                req_idx   <= addr_i >> OFF;
                req_data  <= data_i;
                req_mask  <= mask_i;
            end
            if (flush_i) begin
                count   <= '0;
                error_q <= 1'b0;
                rdata_q <= '0;
            end else begin
                if (accept)                count <= '0;
                else if (state == S_BUSY)  count <= count + 1'b1;
                if (complete) begin
                    error_q <= !in_range;
                    if (!req_write) rdata_q <= in_range ? mem[req_idx[AW-1:0]] : '0;
                end else if (state == S_DONE) begin
                    error_q <= 1'b0;
                end
            end
        end
    end

    // Array has no reset; complete is already false during reset and flush.
    always_ff @(posedge clock_i) begin
        if (complete && req_write && in_range)
            for (int b = 0; b < NBYTES; b++)
                if (req_mask[b]) mem[req_idx[AW-1:0]][8*b +: 8] <= req_data[8*b +: 8];
    end

    assign busy_o  = (state == S_BUSY);
    assign ack_o   = (state == S_DONE);
    assign error_o = error_q;
    assign data_o  = rdata_q;
endmodule

// File: tb/tb_data_memory_param.sv
// Directed + random bench for data_memory_param against a line-array reference model.
module tb_data_memory_param;
    localparam int LB = 256, D = 16, AB = 32, RL = 3, WL = 6;
    localparam int NB = LB / 8;

    logic          clock_i = 0, reset_n_i = 0, flush_i = 0, enable_i = 0, write_i = 0;
    logic [AB-1:0] addr_i = '0;
    logic [LB-1:0] data_i = '0;
    logic [NB-1:0] mask_i = '0;
    logic          busy_o, ack_o, error_o;
    logic [LB-1:0] data_o;

    data_memory_param #(.LINE_BITS(LB), .DEPTH(D), .ADDR_BITS(AB),
                        .READ_LATENCY(RL), .WRITE_LATENCY(WL)) dut (
        .clock_i(clock_i), .reset_n_i(reset_n_i), .flush_i(flush_i), .enable_i(enable_i),
        .write_i(write_i), .addr_i(addr_i), .data_i(data_i), .mask_i(mask_i),
        .busy_o(busy_o), .ack_o(ack_o), .error_o(error_o), .data_o(data_o));

    always #5 clock_i = ~clock_i;

    logic [LB-1:0] mem_m [D];
    logic [LB-1:0] exp_data = '0;
    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LB-1:0] rand_line();
        logic [LB-1:0] v;
        for (int i = 0; i < LB / 32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [LB-1:0] merge(input logic [LB-1:0] old, input logic [LB-1:0] d,
                                            input logic [NB-1:0] m);
        logic [LB-1:0] r = old;
        for (int b = 0; b < NB; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Issues one request, scrambles inputs during BUSY, and returns in the ack cycle
    // so the caller may chain the next request back-to-back.
    task automatic req(input logic wr, input logic [AB-1:0] a, input logic [LB-1:0] d,
                       input logic [NB-1:0] m);
        int lat, k, idx;
        bit oob;
        idx = int'(a >> 5);
        oob = (a >> 5) >= D;
        lat = wr ? WL : RL;
        enable_i = 1; write_i = wr; addr_i = a; data_i = d; mask_i = m;
        @(posedge clock_i); #1;
        chk("busy_after_accept", busy_o, 1);
        chk("err_in_busy", error_o, 0);
        k = 0;
        while (k < 40) begin
            enable_i = 1'($urandom); write_i = 1'($urandom);
            addr_i = $urandom; data_i = rand_line(); mask_i = $urandom;
            @(posedge clock_i); #1;
            k++;
            if (ack_o) break;
            if (!busy_o) begin chk("busy_hold", busy_o, 1); break; end
        end
        enable_i = 0; write_i = 0;
        chk("ack_seen", ack_o, 1);
        chk("latency", k, lat);
        chk("busy_in_ack", busy_o, 0);
        chk("error_flag", error_o, oob);
        if (!oob && wr) mem_m[idx] = merge(mem_m[idx], d, m);
        if (!wr) exp_data = oob ? '0 : mem_m[idx];
        chk("data_o", data_o, exp_data);
    endtask

    task automatic idle_step();
        enable_i = 0;
        @(posedge clock_i); #1;
        chk("idle_ack", ack_o, 0);
        chk("idle_busy", busy_o, 0);
        chk("idle_err", error_o, 0);
        chk("idle_data", data_o, exp_data);
    endtask

    initial begin
        logic [LB-1:0] a5, ff, ones, tmp;
        int acks;
        a5 = {NB{8'hA5}}; ff = {NB{8'hFF}}; ones = {NB{8'h11}};

        repeat (3) @(posedge clock_i);
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_ack", ack_o, 0);
        chk("rst_err", error_o, 0);
        chk("rst_data", data_o, 0);
        @(negedge clock_i) reset_n_i = 1;

        // Fill every line, chained back-to-back
        for (int i = 0; i < D; i++) req(1, AB'(i * 32), rand_line(), '1);
        idle_step();

        // Full-mask write then read issued in the ack cycle
        req(1, 32'hE0, a5, '1);
        req(0, 32'hE0, '0, '0);
        chk("line7_a5", data_o, a5);
        idle_step();

        // Partial write over line 7
        req(1, 32'hE0, ones, 32'h0000000F);
        req(0, 32'hE0, '0, '0);
        tmp = a5; tmp[31:0] = 32'h11111111;
        chk("line7_partial", data_o, tmp);
        idle_step();

        // Out-of-range read and write; aliasing line 0 must stay untouched
        req(0, AB'(D * 32), '0, '0);
        chk("oob_rd_data", data_o, 0);
        req(1, AB'(D * 32), rand_line(), '1);
        idle_step();
        req(0, 32'hE0, '0, '0);
        req(1, AB'(D * 32 + 32), rand_line(), '1);
        chk("oob_wr_hold", data_o, tmp);
        req(0, 32'h0, '0, '0);
        idle_step();

        // Flush four cycles into a write of line 2
        enable_i = 1; write_i = 1; addr_i = 32'h40; data_i = ff; mask_i = '1;
        @(posedge clock_i); #1;
        enable_i = 0; write_i = 0;
        repeat (3) @(posedge clock_i);
        #1 flush_i = 1;
        @(posedge clock_i); #1;
        flush_i = 0;
        exp_data = '0;
        chk("flush_busy", busy_o, 0);
        chk("flush_ack", ack_o, 0);
        chk("flush_data", data_o, 0);
        acks = 0;
        repeat (WL + 2) begin
            @(posedge clock_i); #1;
            if (ack_o) acks++;
        end
        chk("flush_no_ack", acks, 0);
        req(0, 32'h40, '0, '0);
        idle_step();

        // Asynchronous reset in the middle of a write to line 5
        enable_i = 1; write_i = 1; addr_i = 32'hA0; data_i = rand_line(); mask_i = '1;
        @(posedge clock_i); #1;
        enable_i = 0;
        repeat (2) @(posedge clock_i);
        @(negedge clock_i) reset_n_i = 0;
        #1;
        exp_data = '0;
        chk("arst_busy", busy_o, 0);
        chk("arst_ack", ack_o, 0);
        chk("arst_err", error_o, 0);
        chk("arst_data", data_o, 0);
        @(negedge clock_i) reset_n_i = 1;
        idle_step();
        req(0, 32'hA0, '0, '0);
        idle_step();

        // Random mix of in-range and out-of-range traffic
        for (int n = 0; n < 60; n++) begin
            logic [AB-1:0] a;
            a = AB'($urandom_range(0, D + 2) * 32 + $urandom_range(0, 31));
            req(1'($urandom), a, rand_line(), $urandom);
            if ($urandom_range(0, 2) == 0) idle_step();
        end
        idle_step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/data_memory_param.md
# data_memory_param

Parametrised line-oriented backing memory for the cache hierarchy. It replaces the fixed 256-bit, 512-entry, single-latency data memory. It adds:
- separate read and write latencies
- per-byte write masking
- request latching at accept
- an out-of-range error flag
- back-to-back acceptance on the completion cycle

It sits below the L1 data cache controller and serves one line-sized read or write at a time.

## Interface
- LINE_BITS, 256, line width in bits; multiple of 8, power of two ≥ 32
- DEPTH, 512, number of lines
- ADDR_BITS, 32, byte address width
- READ_LATENCY, 10, cycles from accept edge to read completion edge; ≥ 1
- WRITE_LATENCY, 10, cycles from accept edge to write completion edge; ≥ 1

- clock_i  in  1  clock, rising edge
- reset_n_i  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous abort of in-flight request
- enable_i  in  1  request valid
- write_i  in  1  1 = write, 0 = read; sampled at accept
- addr_i  in  ADDR_BITS  byte address; line index = addr_i >> log2(LINE_BITS/8)
- data_i  in  LINE_BITS  write data; sampled at accept
- mask_i  in  LINE_BITS/8  byte write enables; bit b covers data bits [8b+7:8b]; sampled at accept
- busy_o  out  1  request in flight; requests ignored
- ack_o  out  1  one-cycle completion pulse
- error_o  out  1  valid with ack_o; index ≥ DEPTH
- data_o  out  LINE_BITS  read data of last completed read

## Operation
- States: IDLE, BUSY, DONE. Two-bit state register; latency counter wide enough for max(READ_LATENCY, WRITE_LATENCY).
- Accept occurs on a rising edge where state ∈ {IDLE, DONE}, enable_i=1 and flush_i=0.
  - Latch write_i, line index, data_i and mask_i into request registers.
  - Clear the counter and enter BUSY.
- In BUSY, enable_i and all request inputs are ignored; the counter increments each edge.
- Let L = the latency for the latched direction. On the edge where count == L−1, perform the access and enter DONE.
  - Write with index < DEPTH: for each byte b, mem[index] byte b ← latched data byte b if mask bit b = 1, else unchanged. data_o holds its value.
  - Read with index < DEPTH: data_o ← mem[index]; mask is ignored.
  - Index ≥ DEPTH: no array access. data_o ← 0 for a read and holds for a write. The error register is set.
- DONE lasts one cycle. Without a new accept it goes to IDLE; the error register clears on leaving DONE.
- flush_i=1 at an edge: state → IDLE, counter → 0, error → 0, data_o → 0; the in-flight write is discarded with no array update. flush_i takes priority over accept and completion on the same edge.
- The array is never cleared by reset or flush; its contents are undefined until written.

## Timing
- Reset values while reset_n_i=0: state IDLE, busy_o=0, ack_o=0, error_o=0, data_o=0, counter 0. Reset asserted mid-request aborts with no array write.
- busy_o = (state == BUSY); ack_o = (state == DONE); error_o = error register. All are registered, with no combinational path from inputs.
- For an accept on edge E0, ack_o and the final data_o/error_o become visible after edge E0+L and stay valid for exactly one cycle. data_o holds until the next read completion, flush or reset.
- Back-to-back: enable_i=1 during the ack_o cycle is accepted at that edge, so sustained throughput is one request per L+1 cycles.
- L=1: an accept at E0 is followed by DONE after E0+1, with busy_o high for one cycle.
- Read-after-write to the same line, issued in the write's ack cycle, returns the merged data.
- Inputs need only be valid in the accept cycle; the requester may change them during BUSY.

## Test plan
- Reset, then read line 3 with READ_LATENCY=10: busy_o is high for 10 cycles, ack_o pulses once exactly 10 edges after accept, error_o=0.
- Full-mask write of 0xA5…A5 to line 7 (addr 0xE0 at 256 bits), then a back-to-back read issued in the ack cycle: data_o=0xA5…A5 after READ_LATENCY+1 more cycles, with no idle cycle between requests.
- Partial write with mask=0x0000000F and data=0x11…11 over line 7: a subsequent read returns low 4 bytes 0x11 and the remaining bytes 0xA5.
- Read at addr = DEPTH·32: ack_o with error_o=1 and data_o=0, and the array is unchanged. A following write at the same address leaves the previous data_o untouched.
- Flush asserted 4 cycles into a write of 0xFF…FF to line 2: ack_o never pulses, busy_o falls after that edge, and a later read of line 2 returns its old contents.
- With READ_LATENCY=3, WRITE_LATENCY=6: ack_o comes 3 and 6 edges after accept respectively. Deassert reset_n_i mid-BUSY: all outputs go to 0 immediately with no array write.
